vblank_update_sequencer: RTL
============================

Name: vblank_update_sequencer

Overview:
Schedules per-frame game-state updates (tanks, bullets, map, score) into the vertical blanking interval of the 800x600 SVGA frame (1056x628 total, vblank = 28 lines = 29568 pclk cycles).
- On each vblank rising edge, fires one start pulse to each client in fixed order 0..N_CLIENTS-1 and waits for that client's done before starting the next.
- Sits between the VGA timing generator and the game-logic modules.
- Flags frames where updates did not finish before active video resumed.

Parameters:
- N_CLIENTS, 4, number of sequenced update clients (2..8); CLIENT_W = $clog2(N_CLIENTS) derived locally.
- TIMEOUT_CYC, 4096, per-client watchdog limit in pclk cycles (used only with SEQ_TIMEOUT_EN).
- FRAME_CNT_W, 16, width of the completed-frame counter.

Ports:
- pclk  input  1  pixel clock (40 MHz); all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- vblank  input  1  vertical blanking level from the timing generator, synchronous to pclk.
- done  input  N_CLIENTS  per-client completion pulse/level.
- start  output  N_CLIENTS  one-hot, single-cycle start pulse per client.
- active_client  output  CLIENT_W  index of the client currently started or awaited.
- busy  output  1  high from the first start until sequence end or abort.
- frame_done  output  1  single-cycle pulse when all clients have completed in this vblank.
- overrun  output  1  sticky: a sequence was aborted by vblank falling.
- timeout_flag  output  N_CLIENTS  sticky per-client watchdog flags.
- frame_cnt  output  FRAME_CNT_W  count of completed sequences.

Behaviour:
- Reset: all outputs 0; state IDLE; index 0; vblank_d = 1. A vblank already high at reset release does not trigger a sequence.
- All outputs are registered. rst asserted mid-sequence clears start and busy immediately.
- Edge detect: rise = vblank & ~vblank_d (vblank_d is vblank delayed one pclk).
- States: IDLE, START, WAIT, FIN.
  - IDLE: on rise, go to START with index = 0.
  - START: start[index] = 1 for exactly one cycle; busy = 1; go to WAIT.
  - WAIT: the done cycle coincident with the start pulse is ignored; done[index] is sampled from the following cycle on.
    - On done[index]: if index == N_CLIENTS-1, go to FIN; otherwise index++ and go to START.
    - start[index+1] is high in the cycle immediately after the cycle in which done[index] was sampled high.
  - FIN: frame_done = 1 for one cycle; frame_cnt++ (wraps to 0 at all-ones); busy = 0; go to IDLE.
- Latency: start[0] is high in the second pclk cycle after the first edge that samples vblank = 1.
- Done lines of non-active clients are ignored in all states.
- Abort: vblank sampled 0 while in START or WAIT:
  - overrun <= 1, go to IDLE, busy = 0;
  - no further starts; no frame_done; frame_cnt unchanged.
  - The next frame restarts at client 0.
- Simultaneous events:
  - done of the last client and vblank falling in the same cycle: completion wins (FIN, no overrun).
  - done[index] and vblank falling on a non-last client: abort wins.
- overrun and timeout_flag clear only on rst.
- active_client holds its last value in IDLE.

Optional Feature:
SEQ_TIMEOUT_EN
- Defined: a wait counter clears on entry to WAIT and counts pclk cycles. When it reaches TIMEOUT_CYC without done[index]:
  - timeout_flag[index] <= 1;
  - the block proceeds exactly as if done had arrived (next START or FIN).
  - frame_done still pulses; frame_cnt still increments.
- Not defined: no counter is built; timeout_flag is constant 0; WAIT exits only on done or abort.

Test Plan:
1. Reset, then vblank rises for 29568 cycles; each client returns done 10 cycles after its start -> start[0..3] in order, rising edges 11 cycles apart; one frame_done pulse; frame_cnt = 1; overrun = 0; busy low after FIN.
2. Client 2 never asserts done (macro off) -> start[3] never fires; at vblank fall overrun = 1, frame_cnt stays 0; next vblank restarts at start[0] with overrun still 1.
3. SEQ_TIMEOUT_EN with TIMEOUT_CYC = 100; client 1 silent -> start[2] follows start[1] by 101 cycles; timeout_flag = 4'b0010; frame_done pulses; frame_cnt = 1.
4. done[3] held high while client 0 is awaited, and done[0] asserted coincident with start[0] -> both ignored; start[1] fires only after a later done[0].
5. done[3] asserted in the same cycle vblank is first sampled low -> frame_done = 1, overrun = 0; done[1] on the abort cycle -> overrun = 1.
6. vblank high at reset release -> no start until vblank goes low, then high; rst pulsed mid-WAIT -> start, busy, flags and frame_cnt all 0 asynchronously.

Source files
------------

// File: rtl/vblank_update_sequencer.sv
// vblank_update_sequencer
// Runs the per-frame game-state updates inside vertical blanking. On each
// vblank rising edge the clients are started one after another in index
// order; each client must return done before the next one is started.
// A sequence still running when active video resumes is abandoned and
// recorded in the sticky overrun flag.
//
// Optional build macro: SEQ_TIMEOUT_EN
//   Adds a per-client watchdog. A client that stays silent for TIMEOUT_CYC
//   cycles is treated as done, and its bit in timeout_flag is set.
//   Without the macro no counter is built and timeout_flag is tied to 0.
module vblank_update_sequencer #(
  parameter int N_CLIENTS   = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int FRAME_CNT_W = 16,
  localparam int CLIENT_W   = $clog2(N_CLIENTS)
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   vblank,
  input  logic [N_CLIENTS-1:0]   done,
  output logic [N_CLIENTS-1:0]   start,
  output logic [CLIENT_W-1:0]    active_client,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic [N_CLIENTS-1:0]   timeout_flag,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  localparam logic [CLIENT_W-1:0] LAST_IDX = CLIENT_W'(N_CLIENTS - 1);

  state_t                 state_reg, state_next;
  logic [CLIENT_W-1:0]    index_reg, index_next;
  logic                   vblank_d_reg;
  logic                   rise_reg;
  logic [N_CLIENTS-1:0]   start_reg, start_next;
  logic                   busy_reg, busy_next;
  logic                   frame_done_reg, frame_done_next;
  logic                   overrun_reg, overrun_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg, frame_cnt_next;
  logic                   last_client;
  logic                   advance;
  logic                   tmo_hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [N_CLIENTS-1:0]  timeout_reg, timeout_next;

  // The counter is 0 in the first WAIT cycle, so a silent client is
  // released after exactly TIMEOUT_CYC cycles of waiting.
  assign tmo_hit = (state_reg == WAIT) &&
                   (wait_cnt_reg == WAIT_CNT_W'(TIMEOUT_CYC - 1));
  assign timeout_flag = timeout_reg;
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = '0;
`endif

  assign last_client = (index_reg == LAST_IDX);
  // Only the awaited client's done line matters; all others are ignored.
  assign advance     = done[index_reg] | tmo_hit;

  // Edge detector: rise is registered once so start[0] lands in the
  // second cycle after vblank is first sampled high.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblank_d_reg <= 1'b1;
      rise_reg     <= 1'b0;
    end else begin
      vblank_d_reg <= vblank;
      rise_reg     <= vblank & ~vblank_d_reg;
    end
  end

  // State and registered outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      index_reg      <= '0;
      start_reg      <= '0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      frame_cnt_reg  <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      timeout_reg    <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      start_reg      <= start_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
      frame_cnt_reg  <= frame_cnt_next;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_reg   <= wait_cnt_next;
      timeout_reg    <= timeout_next;
`endif
    end
  end

  // Next-state logic. START is the cycle in which the start pulse is
  // visible, so done arriving in that cycle is never sampled.
  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    start_next      = '0;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    overrun_next    = overrun_reg;
    frame_cnt_next  = frame_cnt_reg;
`ifdef SEQ_TIMEOUT_EN
    wait_cnt_next   = wait_cnt_reg;
    timeout_next    = timeout_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (rise_reg) begin
          state_next = START;
          index_next = '0;
          start_next = N_CLIENTS'(1);
          busy_next  = 1'b1;
        end
      end
      START: begin
`ifdef SEQ_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
        if (!vblank) begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          overrun_next = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
`ifdef SEQ_TIMEOUT_EN
        wait_cnt_next = wait_cnt_reg + 1'b1;
`endif
        // Completion of the last client beats a simultaneous vblank fall;
        // on any other client the abort wins.
        if (advance && last_client) begin
          state_next      = FIN;
          frame_done_next = 1'b1;
          frame_cnt_next  = frame_cnt_reg + 1'b1;
          busy_next       = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          if (tmo_hit && !done[index_reg]) timeout_next[index_reg] = 1'b1;
`endif
        end else if (!vblank) begin
          state_next   = IDLE;
          busy_next    = 1'b0;
          overrun_next = 1'b1;
        end else if (advance) begin
          state_next = START;
          index_next = index_reg + 1'b1;
          start_next = N_CLIENTS'(1) << (index_reg + 1'b1);
`ifdef SEQ_TIMEOUT_EN
          if (tmo_hit && !done[index_reg]) timeout_next[index_reg] = 1'b1;
`endif
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign start         = start_reg;
  assign active_client = index_reg;
  assign busy          = busy_reg;
  assign frame_done    = frame_done_reg;
  assign overrun       = overrun_reg;
  assign frame_cnt     = frame_cnt_reg;

endmodule
